// File: rtl/snow64_long_div_param_if.sv
// rtl/snow64_long_div_param_if.sv - command/result bundle for the long divider
// master drives commands, slave is the divider.
interface snow64_long_div_param_if #(
  parameter int WIDTH__IN_A = 16,
  parameter int WIDTH__IN_B = 8
);
  logic                   in_start;
  logic                   in_signed;
  logic [WIDTH__IN_A-1:0] in_a;
  logic [WIDTH__IN_B-1:0] in_b;
  logic                   out_can_accept_cmd;
  logic                   out_data_valid;
  logic [WIDTH__IN_A-1:0] out_quot;
  logic [WIDTH__IN_B-1:0] out_rem;
  logic                   out_div_by_zero;

  modport master (
    output in_start, in_signed, in_a, in_b,
    input  out_can_accept_cmd, out_data_valid, out_quot, out_rem, out_div_by_zero
  );

  modport slave (
    input  in_start, in_signed, in_a, in_b,
    output out_can_accept_cmd, out_data_valid, out_quot, out_rem, out_div_by_zero
  );
endinterface

// File: rtl/snow64_long_div_param.sv
// rtl/snow64_long_div_param.sv - radix-2^R iterative long divider (quotient, remainder, divide-by-zero)
// Signed commands and the fix-up state exist only when SNOW64_LONG_DIV_SIGNED_EN is defined.
module snow64_long_div_param #(
  parameter int WIDTH__IN_A   = 16,
  parameter int WIDTH__IN_B   = 8,
  parameter int BITS_PER_ITER = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snow64_long_div_param_if.slave dv
);
  localparam int N     = WIDTH__IN_A;
  localparam int D     = WIDTH__IN_B;
  localparam int R     = BITS_PER_ITER;
  localparam int ITERS = (N + R - 1) / R;
  localparam int NE    = ITERS * R;
  localparam int K     = 1 << R;
  localparam int CW    = D + R;
  localparam int CNTW  = (ITERS > 1) ? $clog2(ITERS) : 1;

`ifdef SNOW64_LONG_DIV_SIGNED_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WORKING, ST_FIXUP} state_t;
`else
  typedef enum logic {ST_IDLE, ST_WORKING} state_t;
`endif

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [NE-1:0]   num_sh;
  logic [D-1:0]    cur;
  logic [N-1:0]    quot_sh;
  logic [CW-1:0]   mult_tab [K];
  logic            dbz;

  logic            can_accept_q;
  logic            valid_q;
  logic [N-1:0]    quot_q;
  logic [D-1:0]    rem_q;
  logic            dbz_q;

  logic [N-1:0]    mag_a;
  logic [D-1:0]    mag_b;
  logic            b_zero;

`ifdef SNOW64_LONG_DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_quot;
  logic neg_rem;
  logic cmd_is_signed;

  always_comb begin
    a_neg = dv.in_signed & dv.in_a[N-1];
    b_neg = dv.in_signed & dv.in_b[D-1];
    mag_a = a_neg ? -dv.in_a : dv.in_a;
    mag_b = b_neg ? -dv.in_b : dv.in_b;
  end
`else
  logic unused_signed;
  assign unused_signed = dv.in_signed;

  always_comb begin
    mag_a = dv.in_a;
    mag_b = dv.in_b;
  end
`endif

  assign b_zero = (dv.in_b == '0);

  logic [CW-1:0]  cur_shift;
  logic [CW-1:0]  cur_new;
  logic [R-1:0]   digit;
  logic [R-1:0]   trial;
  logic [N+R-1:0] q_wide;
  logic [N-1:0]   quot_next;

  // Table is monotonic, so the digit is resolved one bit at a time, MSB first.
  always_comb begin
    cur_shift = {cur, num_sh[NE-1 -: R]};
    digit     = '0;
    trial     = '0;
    for (int i = R - 1; i >= 0; i--) begin
      trial = digit | (R'(1) << i);
      if (mult_tab[trial] <= cur_shift) digit = trial;
    end
    cur_new   = cur_shift - mult_tab[digit];
    q_wide    = {quot_sh, digit};
    quot_next = q_wide[N-1:0];
  end

  // After the subtract cur_new < |b|, so its top R bits are always zero.
  logic unused_hi;
  assign unused_hi = ^{cur_new[CW-1:D], q_wide[N+R-1:N]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      num_sh       <= '0;
      cur          <= '0;
      quot_sh      <= '0;
      dbz          <= 1'b0;
      for (int k = 0; k < K; k++) mult_tab[k] <= '0;
      can_accept_q <= 1'b1;
      valid_q      <= 1'b0;
      quot_q       <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
`ifdef SNOW64_LONG_DIV_SIGNED_EN
      neg_quot      <= 1'b0;
      neg_rem       <= 1'b0;
      cmd_is_signed <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (dv.in_start) begin
            state   <= ST_WORKING;
            cnt     <= CNTW'(ITERS - 1);
            num_sh  <= b_zero ? '0 : NE'(mag_a);
            cur     <= '0;
            quot_sh <= '0;
            dbz     <= b_zero;
            // A zero divisor runs as divide-by-one on a zero numerator.
            for (int k = 0; k < K; k++)
              mult_tab[k] <= b_zero ? CW'(k) : CW'(k) * CW'(mag_b);
            can_accept_q <= 1'b0;
            valid_q      <= 1'b0;
`ifdef SNOW64_LONG_DIV_SIGNED_EN
            neg_quot      <= a_neg ^ b_neg;
            neg_rem       <= a_neg;
            cmd_is_signed <= dv.in_signed;
`endif
          end
        end

        ST_WORKING: begin
          num_sh  <= num_sh << R;
          cur     <= cur_new[D-1:0];
          quot_sh <= quot_next;
          cnt     <= cnt - CNTW'(1);
          if (cnt == '0) begin
`ifdef SNOW64_LONG_DIV_SIGNED_EN
            if (cmd_is_signed) begin
              state <= ST_FIXUP;
            end else begin
              state        <= ST_IDLE;
              quot_q       <= quot_next;
              rem_q        <= cur_new[D-1:0];
              dbz_q        <= dbz;
              valid_q      <= 1'b1;
              can_accept_q <= 1'b1;
            end
`else
            state        <= ST_IDLE;
            quot_q       <= quot_next;
            rem_q        <= cur_new[D-1:0];
            dbz_q        <= dbz;
            valid_q      <= 1'b1;
            can_accept_q <= 1'b1;
`endif
          end
        end

`ifdef SNOW64_LONG_DIV_SIGNED_EN
        ST_FIXUP: begin
          // Truncating division: quotient takes the sign xor, remainder the numerator sign.
          state        <= ST_IDLE;
          quot_q       <= neg_quot ? -quot_sh : quot_sh;
          rem_q        <= neg_rem ? -cur : cur;
          dbz_q        <= dbz;
          valid_q      <= 1'b1;
          can_accept_q <= 1'b1;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dv.out_can_accept_cmd = can_accept_q;
  assign dv.out_data_valid     = valid_q;
  assign dv.out_quot           = quot_q;
  assign dv.out_rem            = rem_q;
  assign dv.out_div_by_zero    = dbz_q;
endmodule

// File: tb/tb_snow64_long_div_param.sv
// tb/tb_snow64_long_div_param.sv - directed and swept checks of the long divider
// Signed vectors run only when SNOW64_LONG_DIV_SIGNED_EN is defined.
module tb_snow64_long_div_param;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sweep_turn = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  snow64_long_div_param_if #(.WIDTH__IN_A(16), .WIDTH__IN_B(8)) div_if ();

  snow64_long_div_param #(
    .WIDTH__IN_A(16), .WIDTH__IN_B(8), .BITS_PER_ITER(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dv    (div_if)
  );

  // Called #1 after an edge; returns edges from E0 (inclusive) to valid.
  task automatic run_cmd(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic sgn, input bit glitch, output int lat, output bit busy_err);
    div_if.in_a      = a;
    div_if.in_b      = b;
    div_if.in_signed = sgn;
    div_if.in_start  = 1'b1;
    @(posedge clk); #1;
    div_if.in_start = 1'b0;
    check_eq({tag, "_vdrop"}, div_if.out_data_valid, 0);
    lat      = 1;
    busy_err = 1'b0;
    while (!div_if.out_data_valid && lat < 40) begin
      if (div_if.out_can_accept_cmd) busy_err = 1'b1;
      if (glitch && lat == 2) begin
        div_if.in_start = 1'b1;
        div_if.in_a     = 16'd99;
        div_if.in_b     = 8'd3;
      end
      @(posedge clk); #1;
      div_if.in_start = 1'b0;
      lat++;
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input logic sgn, input bit glitch, input logic [15:0] eq,
                            input logic [7:0] er, input logic edz, input int elat);
    int lat;
    bit busy_err;
    run_cmd(tag, a, b, sgn, glitch, lat, busy_err);
    check_eq({tag, "_lat"}, lat, elat);
    check_eq({tag, "_busy"}, busy_err, 0);
    check_eq({tag, "_acc"}, div_if.out_can_accept_cmd, 1);
    check_eq({tag, "_q"}, div_if.out_quot, eq);
    check_eq({tag, "_r"}, div_if.out_rem, er);
    check_eq({tag, "_dbz"}, div_if.out_div_by_zero, edz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    div_if.in_start  = 1'b0;
    div_if.in_signed = 1'b0;
    div_if.in_a      = '0;
    div_if.in_b      = '0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_acc", div_if.out_can_accept_cmd, 1);
    check_eq("rst_valid", div_if.out_data_valid, 0);
    check_eq("rst_q", div_if.out_quot, 0);
    check_eq("rst_r", div_if.out_rem, 0);
    check_eq("rst_dbz", div_if.out_div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    expect_cmd("c1000_7", 16'd1000, 8'd7, 1'b0, 1'b0, 16'd142, 8'd6, 1'b0, 7);
    expect_cmd("cmax", 16'd65535, 8'd255, 1'b0, 1'b0, 16'd257, 8'd0, 1'b0, 7);
    expect_cmd("c5_9", 16'd5, 8'd9, 1'b0, 1'b0, 16'd0, 8'd5, 1'b0, 7);
    expect_cmd("dbz", 16'd1234, 8'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 7);
    expect_cmd("c10_3", 16'd10, 8'd3, 1'b0, 1'b0, 16'd3, 8'd1, 1'b0, 7);

    // Abort a command between E2 and E3.
    div_if.in_a     = 16'd1000;
    div_if.in_b     = 8'd7;
    div_if.in_start = 1'b1;
    @(posedge clk); #1;
    div_if.in_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_acc", div_if.out_can_accept_cmd, 1);
    check_eq("mid_valid", div_if.out_data_valid, 0);
    check_eq("mid_q", div_if.out_quot, 0);
    check_eq("mid_r", div_if.out_rem, 0);
    check_eq("mid_dbz", div_if.out_div_by_zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_cmd("post_rst", 16'd50, 8'd5, 1'b0, 1'b1, 16'd10, 8'd0, 1'b0, 7);

`ifdef SNOW64_LONG_DIV_SIGNED_EN
    expect_cmd("s_m100_7", 16'hFF9C, 8'd7, 1'b1, 1'b0, 16'hFFF2, 8'hFE, 1'b0, 8);
    expect_cmd("s_100_m7", 16'd100, 8'hF9, 1'b1, 1'b0, 16'hFFF2, 8'd2, 1'b0, 8);
    expect_cmd("s_min_m1", 16'h8000, 8'hFF, 1'b1, 1'b0, 16'h8000, 8'd0, 1'b0, 8);
    expect_cmd("s_dbz", 16'hFF9C, 8'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b1, 8);
    expect_cmd("s_uns", 16'hFF9C, 8'd7, 1'b0, 1'b0, 16'd9348, 8'd0, 1'b0, 7);
`else
    expect_cmd("ign_sgn", 16'hFF9C, 8'd7, 1'b1, 1'b0, 16'd9348, 8'd0, 1'b0, 7);
`endif

    sweep_turn = 1;
    wait (sweep_turn == 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SR     = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 3;
    localparam int SN     = 32;
    localparam int SD     = 16;
    localparam int SITERS = (SN + SR - 1) / SR;

    snow64_long_div_param_if #(.WIDTH__IN_A(SN), .WIDTH__IN_B(SD)) sif ();

    snow64_long_div_param #(
      .WIDTH__IN_A(SN), .WIDTH__IN_B(SD), .BITS_PER_ITER(SR)
    ) sdut (
      .clk   (clk),
      .rst_n (rst_n),
      .dv    (sif)
    );

    initial begin
      logic [31:0] a;
      logic [31:0] eq;
      logic [15:0] b;
      logic [15:0] er;
      int          lat;
      sif.in_start  = 1'b0;
      sif.in_signed = 1'b0;
      sif.in_a      = '0;
      sif.in_b      = '0;
      wait (sweep_turn == g + 1);
      for (int t = 0; t < 12; t++) begin
        case (t)
          0:       begin a = 32'hFFFF_FFFF; b = 16'd1;      end
          1:       begin a = 32'hFFFF_FFFF; b = 16'hFFFF;   end
          2:       begin a = 32'd123456789; b = 16'd0;      end
          3:       begin a = 32'd7;         b = 16'd40000;  end
          default: begin
            a = $urandom >> $urandom_range(0, 31);
            b = 16'($urandom) >> $urandom_range(0, 15);
          end
        endcase
        if (b == '0) begin
          eq = '0;
          er = '0;
        end else begin
          eq = a / 32'(b);
          er = 16'(a % 32'(b));
        end
        sif.in_a     = a;
        sif.in_b     = b;
        sif.in_start = 1'b1;
        @(posedge clk); #1;
        sif.in_start = 1'b0;
        lat = 1;
        while (!sif.out_data_valid && lat < 60) begin
          @(posedge clk); #1;
          lat++;
        end
        check_eq($sformatf("sw_r%0d_t%0d_lat", SR, t), lat, SITERS + 1);
        check_eq($sformatf("sw_r%0d_t%0d_q", SR, t), sif.out_quot, eq);
        check_eq($sformatf("sw_r%0d_t%0d_r", SR, t), sif.out_rem, er);
        check_eq($sformatf("sw_r%0d_t%0d_dbz", SR, t), sif.out_div_by_zero, b == '0);
      end
      sweep_turn = g + 2;
    end
  end
endmodule
